// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: register map, STATUS bit
// positions, transmit FSM state type and the reset baud divisor.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  // 25 MHz / (216 + 1) is within 0.01% of 115200 baud.
  localparam logic [15:0] DIV_RESET_DEFAULT = 16'd216;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Byte-wide synchronous FIFO. A push into a full FIFO is accepted only when
// a pop happens in the same cycle; otherwise it is ignored.
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop & (count_q != '0);
    do_push  = push & ((count_q != (AW+1)'(DEPTH)) | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/uart_tx.sv
// Bus-mapped UART transmitter with FIFO and programmable baud divisor.
// Define UART_TX_IRQ_EN to build the CTRL.irq_en register and the irq_o output.
module uart_tx
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = DIV_RESET_DEFAULT
) (
  input  logic        clk_25mhz,
  input  logic        rst_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic        stb_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  output logic        tx,
  output logic        irq_o,
  output tx_state_e   dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Bus handshake: an access starts on the first cycle stb_i is seen high;
  // ack_o follows one cycle later for exactly one cycle, and a strobe held
  // past its ack does not start another access until it drops.
  logic        stb_seen_q, ack_q;
  logic [31:0] dat_q, dat_d, rd_word, status_word, ctrl_word;
  logic        access, wr_acc, push_req;
  logic [1:0]  reg_idx;
  logic [15:0] div_q, div_d;
  logic        ovf_q, ovf_d;

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d, bit_end;

  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;
  logic [AW:0] fifo_count;

  logic unused_bits;
  assign unused_bits = ^{adr_i[31:4], adr_i[1:0], dat_i[31:16], sel_i[3:2]};

  assign reg_idx = adr_i[3:2];

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_25mhz),
    .rst   (rst_i),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (dat_i[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    access   = stb_i & ~stb_seen_q;
    wr_acc   = access & we_i;
    push_req = wr_acc & (reg_idx == REG_DATA) & sel_i[0];

    div_d = div_q;
    if (wr_acc && reg_idx == REG_DIV) begin
      if (sel_i[0]) div_d[7:0]  = dat_i[7:0];
      if (sel_i[1]) div_d[15:8] = dat_i[15:8];
    end

    ovf_d = ovf_q;
    if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;
    if (wr_acc && reg_idx == REG_STATUS && sel_i[0] && dat_i[STAT_OVF]) ovf_d = 1'b0;

    status_word             = '0;
    status_word[STAT_FULL]  = fifo_full;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_BUSY]  = (state_q != ST_IDLE);
    status_word[STAT_OVF]   = ovf_q;
    status_word[15:8]       = 8'(fifo_count);

    case (reg_idx)
      REG_STATUS: rd_word = status_word;
      REG_DIV:    rd_word = {16'd0, div_q};
      REG_CTRL:   rd_word = ctrl_word;
      default:    rd_word = '0;
    endcase
    dat_d = (access && !we_i) ? rd_word : '0;
  end

  // Every bit lasts baud+1 cycles: baud is loaded from DIV as the bit starts
  // and the bit ends on the cycle it reads zero.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    bit_end   = (baud_q == 16'd0);
    if (state_q != ST_IDLE && !bit_end) baud_d = baud_q - 16'd1;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = div_q;
          tx_d     = 1'b0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = 3'd0;
          baud_d    = div_q;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d = div_q;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            baud_d   = div_q;
            tx_d     = 1'b0;
            state_d  = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst_i) begin
      stb_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      div_q      <= DIV_RESET;
      ovf_q      <= 1'b0;
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      stb_seen_q <= stb_i;
      ack_q      <= access;
      dat_q      <= dat_d;
      div_q      <= div_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_acc && reg_idx == REG_CTRL && sel_i[0]) irq_en_d = dat_i[0];
    irq_d = irq_en_q & fifo_empty & (state_q == ST_IDLE);
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst_i) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_o     = irq_q;
  assign ctrl_word = {31'd0, irq_en_q};
`else
  assign irq_o     = 1'b0;
  assign ctrl_word = '0;
`endif

  assign ack_o       = ack_q;
  assign dat_o       = dat_q;
  assign tx          = tx_q;
  assign dbg_state_o = state_q;

endmodule
